// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD digit converter.
// The state encoding is fixed so that other blocks can decode the state register directly.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // Evaluated at elaboration time to size the overflow limit from the digit count.
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One decimal digit of the shift-and-add-3 step: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decade.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Digits above 12 never occur for in-range inputs; the 4-bit wrap is harmless there.
  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_digits.sv
// Sequential shift-and-add-3 binary-to-BCD converter with a start/busy/done handshake.
// The result and overflow flag are held between conversions so the displays stay steady.
module bin_to_bcd_digits
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int          SCR_W   = 4 * DIGITS;
  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
  localparam int          CNT_W   = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam int          CMP_W   = max_int(BIN_WIDTH, $clog2(MAX_VAL + 1));

  localparam logic [CMP_W-1:0] MAX_CMP  = CMP_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [SCR_W-1:0]     scratch;
  logic [SCR_W-1:0]     adjusted;
  logic [SCR_W-1:0]     scratch_shifted;
  logic                 ovf_pend;
  logic                 ovf_in;
  logic                 accept;
  logic                 last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (scratch[4*g +: 4]),
      .adjusted (adjusted[4*g +: 4])
    );
  end

  // Adjust every digit first, then shift the whole {scratch, shift_reg} pair left by one.
  assign scratch_shifted = {adjusted[SCR_W-2:0], shift_reg[BIN_WIDTH-1]};

  assign ovf_in     = CMP_W'(bin) > MAX_CMP;
  assign accept     = (state == S_IDLE) && start;
  assign last_shift = (state == S_SHIFT) && (cnt == LAST_CNT);

  // NOTE: every always_comb output gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SHIFT;
      S_SHIFT:  if (cnt == LAST_CNT) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: the datapath registers are plain flops, not a memory, so they are all reset;
  // an aborted conversion leaves nothing behind.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      ovf_pend  <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      shift_reg <= bin;
      scratch   <= '0;
      cnt       <= '0;
      ovf_pend  <= ovf_in;
    end else if (state == S_SHIFT) begin
      scratch   <= scratch_shifted;
      shift_reg <= shift_reg << 1;
      cnt       <= cnt + CNT_W'(1);
      if (last_shift) begin
        bcd      <= ovf_pend ? {DIGITS{BCD_NINE}} : scratch_shifted;
        overflow <= ovf_pend;
      end
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_FINISH);

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Directed self-checking bench for bin_to_bcd_digits (BIN_WIDTH=14, DIGITS=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bin_to_bcd_digits;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  bin_to_bcd_digits #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Independent decimal reference: digit extraction by division, saturated to 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    if (v > 9999) return 16'h9999;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'(v / 1000);
    return r;
  endfunction

  // One full conversion: edges counts the accepting edge as edge 1.
  task automatic run_conv(input string tag, input int v);
    int edges;
    int busy_cycles;
    bit seen;
    @(negedge clock);
    bin   = 14'(v);
    start = 1'b1;
    @(posedge clock);
    edges = 1;
    busy_cycles = 0;
    seen = 1'b0;
    #1 start = 1'b0;
    while (edges < 40) begin
      @(negedge clock);
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock);
      edges++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_edges"}, 32'(edges), 32'd15);
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd14);
    check({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
    check({tag, "_ovf"}, 32'(overflow), (v > 9999) ? 32'd1 : 32'd0);
    @(negedge clock);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    int cyc;
    bit stable;
    logic [15:0] held;

    resetn = 1'b0;
    start  = 1'b0;
    bin    = '0;
    repeat (2) @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd), 32'h0);
    check("reset_ovf", 32'(overflow), 32'd0);
    resetn = 1'b1;

    // Latency, zero value, normal and boundary values, overflow and its recovery.
    run_conv("zero", 0);
    run_conv("v1234", 1234);
    run_conv("v9999", 9999);
    run_conv("v12345", 12345);
    run_conv("v7", 7);
    run_conv("v10000", 10000);
    run_conv("v16383", 16383);
    run_conv("v5090", 5090);

    // start re-pulsed mid-SHIFT and during FINISH must be ignored.
    @(negedge clock);
    bin   = 14'd321;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(negedge clock);
    start = 1'b1;
    bin   = 14'd42;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("ignore_done_seen", 32'(done), 32'd1);
    check("ignore_bcd", 32'(bcd), 32'h0321);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    dones = 0;
    n = 0;
    repeat (25) begin
      @(negedge clock);
      if (done) dones++;
      if (busy) n++;
    end
    check("ignore_extra_done", 32'(dones), 32'd0);
    check("ignore_extra_busy", 32'(n), 32'd0);
    check("ignore_bcd_held", 32'(bcd), 32'h0321);

    // Reset asserted in the sixth SHIFT cycle aborts the conversion.
    @(negedge clock);
    bin   = 14'd1234;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (6) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd), 32'h0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_conv("v58", 58);

    // start held high: back-to-back conversions of 0..200, one every 16 cycles.
    @(negedge clock);
    held  = bcd;
    bin   = 14'd0;
    start = 1'b1;
    for (int i = 0; i <= 200; i++) begin
      cyc = 0;
      stable = 1'b1;
      do begin
        @(negedge clock);
        cyc++;
        if (!done && bcd !== held) stable = 1'b0;
      end while (!done && cyc < 40);
      check($sformatf("b2b_done_%0d", i), 32'(done), 32'd1);
      check($sformatf("b2b_bcd_%0d", i), 32'(bcd), 32'(ref_bcd(i)));
      check($sformatf("b2b_stable_%0d", i), 32'(stable), 32'd1);
      if (i > 0) check($sformatf("b2b_period_%0d", i), 32'(cyc), 32'd16);
      held = bcd;
      if (i < 200) bin = 14'(i + 1);
      else         start = 1'b0;
    end
    repeat (20) @(negedge clock);
    check("b2b_final_idle", 32'(busy), 32'd0);
    check("b2b_final_bcd", 32'(bcd), 32'h0200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
